// File: rtl/cpu_defs.sv
// cpu_defs: shared definitions for the VRAM/OAM busmaster arbiter.
//   arb_state_e : arbiter FSM states
//   ppu_mode_e  : PPU mode as reported by the LCD controller
//   region_e    : decoded target memory of a bus address
//   *_BASE/*_END: address windows of the two video memories
package cpu_defs;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_BLOCKED = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        MODE_HBL  = 2'd0,
        MODE_VBL  = 2'd1,
        MODE_OAM  = 2'd2,
        MODE_DRAW = 2'd3
    } ppu_mode_e;

    typedef enum logic [1:0] {
        RGN_NONE = 2'd0,
        RGN_VRAM = 2'd1,
        RGN_OAM  = 2'd2
    } region_e;

    localparam logic [15:0] VRAM_BASE = 16'h8000;
    localparam logic [15:0] VRAM_END  = 16'h9FFF;
    localparam logic [15:0] OAM_BASE  = 16'hFE00;
    localparam logic [15:0] OAM_END   = 16'hFE9F;

endpackage

// File: rtl/vram_oam_decode.sv
// vram_oam_decode: combinational address decode and access-lock evaluation.
//   addr_i       : 16-bit bus address of the candidate winner
//   is_dma_i     : candidate is the DMA master (never locked)
//   lcd_on_i     : LCDC bit 7
//   ppu_mode_i   : current PPU mode
//   dma_active_i : OAM DMA transfer in progress
//   region_o     : VRAM / OAM / unmapped
//   locked_o     : access must be blocked because the PPU owns the memory
//   vram_addr_o  : local VRAM address
//   oam_addr_o   : local OAM address
module vram_oam_decode
    import cpu_defs::*;
(
    input  logic [15:0] addr_i,
    input  logic        is_dma_i,
    input  logic        lcd_on_i,
    input  logic [1:0]  ppu_mode_i,
    input  logic        dma_active_i,
    output region_e     region_o,
    output logic        locked_o,
    output logic [12:0] vram_addr_o,
    output logic [7:0]  oam_addr_o
);

    ppu_mode_e mode;
    assign mode = ppu_mode_e'(ppu_mode_i);

    always_comb begin
        region_o = RGN_NONE;
        if (addr_i >= VRAM_BASE && addr_i <= VRAM_END) begin
            region_o = RGN_VRAM;
        end else if (addr_i >= OAM_BASE && addr_i <= OAM_END) begin
            region_o = RGN_OAM;
        end
    end

    // Unmapped accesses are blocked by region alone, so lock only matters
    // for mapped CPU accesses.
    always_comb begin
        locked_o = 1'b0;
        if (!is_dma_i && region_o != RGN_NONE) begin
            if (dma_active_i) begin
                locked_o = 1'b1;
            end else if (lcd_on_i && mode == MODE_DRAW) begin
                locked_o = 1'b1;
            end else if (lcd_on_i && mode == MODE_OAM && region_o == RGN_OAM) begin
                locked_o = 1'b1;
            end
        end
    end

    assign vram_addr_o = addr_i[12:0];
    assign oam_addr_o  = addr_i[7:0];

endmodule

// File: rtl/vram_oam_arbiter.sv
// vram_oam_arbiter: arbitrates CPU and OAM-DMA busmasters onto VRAM and OAM,
// enforcing PPU access locks.
//   clk_4mhz, rst                     : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata, ack/rdata  : CPU master (request held until ack)
//   dma_req/we/addr/wdata, ack/rdata  : DMA master (request held until ack)
//   dma_active, lcd_on, ppu_mode      : lock context, sampled at grant only
//   vram_en/we/addr/wdata, vram_rdata : VRAM port, 1-cycle read latency
//   oam_en/we/addr/wdata, oam_rdata   : OAM port, 1-cycle read latency
// Normal access: grant, ISSUE, WAIT(ack). Blocked/unmapped: grant, BLOCKED(ack).
module vram_oam_arbiter
    import cpu_defs::*;
#(
    parameter logic [7:0] OPEN_BUS = 8'hFF
) (
    input  logic        clk_4mhz,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    input  logic        dma_active,
    input  logic        lcd_on,
    input  logic [1:0]  ppu_mode,
    output logic        vram_en,
    output logic        vram_we,
    output logic [12:0] vram_addr,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata,
    output logic        oam_en,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    input  logic [7:0]  oam_rdata
);

    arb_state_e  state_q, state_d;
    logic        own_dma_q, own_dma_d;
    logic        we_q, we_d;
    region_e     region_q, region_d;
    logic [12:0] vaddr_q, vaddr_d;
    logic [7:0]  oaddr_q, oaddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  dma_rdata_q, dma_rdata_d;

    // DMA has fixed priority over the CPU.
    logic        grant_any;
    logic [15:0] cand_addr;
    region_e     dec_region;
    logic        dec_locked;
    logic [12:0] dec_vaddr;
    logic [7:0]  dec_oaddr;

    assign grant_any = dma_req | cpu_req;
    assign cand_addr = dma_req ? dma_addr : cpu_addr;

    vram_oam_decode u_decode (
        .addr_i       (cand_addr),
        .is_dma_i     (dma_req),
        .lcd_on_i     (lcd_on),
        .ppu_mode_i   (ppu_mode),
        .dma_active_i (dma_active),
        .region_o     (dec_region),
        .locked_o     (dec_locked),
        .vram_addr_o  (dec_vaddr),
        .oam_addr_o   (dec_oaddr)
    );

    logic       ack_now;
    logic [7:0] rd_now;

    always_comb begin
        state_d     = state_q;
        own_dma_d   = own_dma_q;
        we_d        = we_q;
        region_d    = region_q;
        vaddr_d     = vaddr_q;
        oaddr_d     = oaddr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        ack_now     = 1'b0;
        rd_now      = OPEN_BUS;

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    own_dma_d = dma_req;
                    we_d      = dma_req ? dma_we : cpu_we;
                    wdata_d   = dma_req ? dma_wdata : cpu_wdata;
                    region_d  = dec_region;
                    vaddr_d   = dec_vaddr;
                    oaddr_d   = dec_oaddr;
                    // Lock is frozen here; later mode changes cannot affect this access.
                    if (dec_region == RGN_NONE || dec_locked) begin
                        state_d = ST_BLOCKED;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                ack_now = 1'b1;
                rd_now  = (region_q == RGN_VRAM) ? vram_rdata : oam_rdata;
                state_d = ST_IDLE;
            end
            ST_BLOCKED: begin
                ack_now = 1'b1;
                rd_now  = OPEN_BUS;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Captured so rdata holds between acks.
        if (ack_now) begin
            if (own_dma_q) begin
                dma_rdata_d = rd_now;
            end else begin
                cpu_rdata_d = rd_now;
            end
        end
    end

    always_ff @(posedge clk_4mhz) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            own_dma_q   <= 1'b0;
            we_q        <= 1'b0;
            region_q    <= RGN_NONE;
            vaddr_q     <= '0;
            oaddr_q     <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= OPEN_BUS;
            dma_rdata_q <= OPEN_BUS;
        end else begin
            state_q     <= state_d;
            own_dma_q   <= own_dma_d;
            we_q        <= we_d;
            region_q    <= region_d;
            vaddr_q     <= vaddr_d;
            oaddr_q     <= oaddr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Outputs are gated by rst so a reset landing on ISSUE/WAIT aborts the
    // memory strobe and the ack in that same cycle.
    logic issue;
    logic ack_ok;

    assign issue  = !rst && (state_q == ST_ISSUE);
    assign ack_ok = !rst && ack_now;

    assign cpu_ack   = ack_ok && !own_dma_q;
    assign dma_ack   = ack_ok && own_dma_q;
    assign cpu_rdata = rst ? OPEN_BUS : (cpu_ack ? rd_now : cpu_rdata_q);
    assign dma_rdata = rst ? OPEN_BUS : (dma_ack ? rd_now : dma_rdata_q);

    assign vram_en    = issue && (region_q == RGN_VRAM);
    assign vram_we    = vram_en && we_q;
    assign vram_addr  = rst ? 13'd0 : vaddr_q;
    assign vram_wdata = rst ? 8'd0 : wdata_q;

    assign oam_en    = issue && (region_q == RGN_OAM);
    assign oam_we    = oam_en && we_q;
    assign oam_addr  = rst ? 8'd0 : oaddr_q;
    assign oam_wdata = rst ? 8'd0 : wdata_q;

endmodule

// File: tb/tb_vram_oam_arbiter.sv
// Bench for vram_oam_arbiter: reset checks, a vector table of directed
// accesses, multi-cycle sequences (priority, reset abort, mode change after
// grant) and randomized accesses against a reference model.
module tb_vram_oam_arbiter;

    logic        clk_4mhz = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = 16'h0;
    logic [7:0]  dma_wdata = 8'h0;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic        dma_active = 1'b0, lcd_on = 1'b1;
    logic [1:0]  ppu_mode = 2'd0;
    logic        vram_en, vram_we;
    logic [12:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic        oam_en, oam_we;
    logic [7:0]  oam_addr, oam_wdata;
    logic [7:0]  oam_rdata;

    always #5 clk_4mhz = ~clk_4mhz;

    vram_oam_arbiter #(.OPEN_BUS(8'hFF)) dut (
        .clk_4mhz(clk_4mhz), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .dma_active(dma_active), .lcd_on(lcd_on), .ppu_mode(ppu_mode),
        .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
        .oam_en(oam_en), .oam_we(oam_we), .oam_addr(oam_addr),
        .oam_wdata(oam_wdata), .oam_rdata(oam_rdata)
    );

    // Memories behind the arbiter: synchronous, 1-cycle read latency.
    logic       mem_clr = 1'b1;
    logic [7:0] vram_mem [8192];
    logic [7:0] oam_mem  [256];

    always @(posedge clk_4mhz) begin
        if (mem_clr) begin
            for (int i = 0; i < 8192; i++) vram_mem[i] <= 8'h00;
            for (int i = 0; i < 256; i++)  oam_mem[i]  <= 8'h00;
        end else begin
            if (vram_en) begin
                if (vram_we) vram_mem[vram_addr] <= vram_wdata;
                vram_rdata <= vram_mem[vram_addr];
            end
            if (oam_en) begin
                if (oam_we) oam_mem[oam_addr] <= oam_wdata;
                oam_rdata <= oam_mem[oam_addr];
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] ref_vram [8192];
    logic [7:0] ref_oam  [256];

    // 0 = unmapped, 1 = VRAM, 2 = OAM
    function automatic int region_of(input logic [15:0] a);
        if (a >= 16'h8000 && a <= 16'h9FFF) return 1;
        if (a >= 16'hFE00 && a <= 16'hFE9F) return 2;
        return 0;
    endfunction

    function automatic bit blocked_of(input bit isd, input logic [15:0] a,
                                      input bit lcd, input logic [1:0] m, input bit dact);
        int r;
        r = region_of(a);
        if (r == 0) return 1'b1;
        if (isd) return 1'b0;
        if (dact) return 1'b1;
        if (lcd && m == 2'd3) return 1'b1;
        if (lcd && m == 2'd2 && r == 2) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        if (region_of(a) == 1) return ref_vram[a - 16'h8000];
        return ref_oam[a - 16'hFE00];
    endfunction

    task automatic ref_apply(input bit isd, input bit w, input logic [15:0] a, input logic [7:0] wd,
                             input bit lcd, input logic [1:0] m, input bit dact);
        if (w && !blocked_of(isd, a, lcd, m, dact)) begin
            if (region_of(a) == 1) ref_vram[a - 16'h8000] = wd;
            else ref_oam[a - 16'hFE00] = wd;
        end
    endtask

    // One access from IDLE. Returns ack latency from the grant cycle, the
    // number of cycles a memory enable was seen, and the acked rdata.
    // Also checks ack lasts one cycle, rdata holds, and the other master
    // never sees an ack.
    task automatic do_access(input bit isd, input bit w, input logic [15:0] a, input logic [7:0] wd,
                             input bit lcd, input logic [1:0] m, input logic [1:0] m_after,
                             input bit dact, output int lat, output int ens, output logic [7:0] rd);
        int wrong;
        lat = -1; ens = 0; rd = 8'h00; wrong = 0;
        lcd_on = lcd; ppu_mode = m; dma_active = dact;
        if (isd) begin
            dma_req = 1'b1; dma_we = w; dma_addr = a; dma_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = w; cpu_addr = a; cpu_wdata = wd;
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk_4mhz);
            if (vram_en || oam_en) ens++;
            if (isd ? cpu_ack : dma_ack) wrong++;
            if (isd ? dma_ack : cpu_ack) begin
                lat = n;
                rd = isd ? dma_rdata : cpu_rdata;
                break;
            end
            @(posedge clk_4mhz); #1;
            if (n == 0) ppu_mode = m_after;
        end
        @(posedge clk_4mhz); #1;
        cpu_req = 1'b0; dma_req = 1'b0;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL ack_timeout addr=%h: no ack within 10 cycles", a);
        end else begin
            @(negedge clk_4mhz);
            chk("ack_one_cycle", int'(isd ? dma_ack : cpu_ack), 0);
            chk("rdata_hold", int'(isd ? dma_rdata : cpu_rdata), int'(rd));
            @(posedge clk_4mhz); #1;
        end
        chk("other_ack", wrong, 0);
    endtask

    typedef struct {
        bit         isd;
        bit         w;
        logic [15:0] a;
        logic [7:0]  wd;
        bit         lcd;
        logic [1:0]  m;
        bit         dact;
        int         lat;
        int         ens;
        bit         chk_rd;
        logic [7:0]  rd;
    } vec_t;

    vec_t vt[$];

    initial begin
        int lat, ens;
        logic [7:0] rd;
        int dack_at, cack_at;
        logic [7:0] crd;

        for (int i = 0; i < 8192; i++) ref_vram[i] = 8'h00;
        for (int i = 0; i < 256; i++)  ref_oam[i]  = 8'h00;

        // isd w  addr      wd     lcd m     dact lat ens chk rd
        vt.push_back('{1'b0,1'b1,16'h8000,8'h5A,1'b1,2'd0,1'b0,2,1,1'b0,8'h00});
        vt.push_back('{1'b0,1'b0,16'h8000,8'h00,1'b1,2'd0,1'b0,2,1,1'b1,8'h5A});
        vt.push_back('{1'b0,1'b0,16'h8000,8'h00,1'b1,2'd3,1'b0,1,0,1'b1,8'hFF});
        vt.push_back('{1'b0,1'b1,16'h9FFF,8'h22,1'b1,2'd0,1'b0,2,1,1'b0,8'h00});
        vt.push_back('{1'b0,1'b1,16'h9FFF,8'h11,1'b1,2'd3,1'b0,1,0,1'b1,8'hFF});
        vt.push_back('{1'b0,1'b0,16'h9FFF,8'h00,1'b1,2'd0,1'b0,2,1,1'b1,8'h22});
        vt.push_back('{1'b1,1'b1,16'hFE00,8'h77,1'b1,2'd2,1'b0,2,1,1'b0,8'h00});
        vt.push_back('{1'b0,1'b0,16'hFE00,8'h00,1'b1,2'd2,1'b0,1,0,1'b1,8'hFF});
        vt.push_back('{1'b0,1'b0,16'hFE00,8'h00,1'b1,2'd0,1'b0,2,1,1'b1,8'h77});
        vt.push_back('{1'b0,1'b0,16'h8000,8'h00,1'b1,2'd0,1'b1,1,0,1'b1,8'hFF});
        vt.push_back('{1'b0,1'b0,16'hFEA0,8'h00,1'b1,2'd0,1'b0,1,0,1'b1,8'hFF});
        vt.push_back('{1'b0,1'b1,16'h8001,8'h33,1'b0,2'd3,1'b0,2,1,1'b0,8'h00});
        vt.push_back('{1'b0,1'b0,16'h8001,8'h00,1'b0,2'd3,1'b0,2,1,1'b1,8'h33});
        vt.push_back('{1'b1,1'b0,16'h8000,8'h00,1'b1,2'd3,1'b1,2,1,1'b1,8'h5A});
        vt.push_back('{1'b0,1'b1,16'hFE9F,8'hC3,1'b1,2'd1,1'b0,2,1,1'b0,8'h00});
        vt.push_back('{1'b0,1'b0,16'hFE9F,8'h00,1'b1,2'd1,1'b0,2,1,1'b1,8'hC3});
        vt.push_back('{1'b0,1'b0,16'h7FFF,8'h00,1'b0,2'd0,1'b0,1,0,1'b1,8'hFF});
        vt.push_back('{1'b0,1'b1,16'hFE10,8'hEE,1'b1,2'd2,1'b0,1,0,1'b1,8'hFF});
        vt.push_back('{1'b0,1'b0,16'h8000,8'h00,1'b1,2'd2,1'b0,2,1,1'b1,8'h5A});

        // ---------------- reset state ----------------
        @(negedge clk_4mhz);
        @(negedge clk_4mhz);
        chk("rst_cpu_ack", int'(cpu_ack), 0);
        chk("rst_dma_ack", int'(dma_ack), 0);
        chk("rst_en", int'({vram_en, vram_we, oam_en, oam_we}), 0);
        chk("rst_cpu_rdata", int'(cpu_rdata), 8'hFF);
        chk("rst_dma_rdata", int'(dma_rdata), 8'hFF);
        chk("rst_addr_data", int'({vram_addr, vram_wdata, oam_addr, oam_wdata}), 0);
        @(posedge clk_4mhz); #1;
        rst = 1'b0; mem_clr = 1'b0;
        @(posedge clk_4mhz); #1;

        // ---------------- vector table ----------------
        foreach (vt[i]) begin
            do_access(vt[i].isd, vt[i].w, vt[i].a, vt[i].wd, vt[i].lcd, vt[i].m, vt[i].m,
                      vt[i].dact, lat, ens, rd);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_mem_en", i), ens, vt[i].ens);
            if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), int'(rd), int'(vt[i].rd));
            ref_apply(vt[i].isd, vt[i].w, vt[i].a, vt[i].wd, vt[i].lcd, vt[i].m, vt[i].dact);
        end

        // ---------------- simultaneous requests: DMA first ----------------
        lcd_on = 1'b1; ppu_mode = 2'd0; dma_active = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8002;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h8002; dma_wdata = 8'hAB;
        dack_at = -1; cack_at = -1; crd = 8'h00;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk_4mhz);
            if (dma_ack && dack_at < 0) dack_at = n;
            if (cpu_ack && cack_at < 0) begin
                cack_at = n;
                crd = cpu_rdata;
            end
            @(posedge clk_4mhz); #1;
            if (dack_at >= 0) dma_req = 1'b0;
            if (cack_at >= 0) cpu_req = 1'b0;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("both_dma_ack_at", dack_at, 2);
        chk("both_cpu_ack_at", cack_at, 5);
        chk("both_cpu_rdata", int'(crd), 8'hAB);
        ref_vram[2] = 8'hAB;

        // ---------------- mode change after grant ----------------
        do_access(1'b0, 1'b0, 16'h8000, 8'h00, 1'b1, 2'd0, 2'd3, 1'b0, lat, ens, rd);
        chk("modechg_latency", lat, 2);
        chk("modechg_rdata", int'(rd), 8'h5A);

        // ---------------- reset during ISSUE ----------------
        lcd_on = 1'b1; ppu_mode = 2'd0; dma_active = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8010; cpu_wdata = 8'h99;
        @(posedge clk_4mhz); #1;
        rst = 1'b1;
        @(negedge clk_4mhz);
        chk("rstissue_ack", int'({cpu_ack, dma_ack}), 0);
        chk("rstissue_en", int'({vram_en, vram_we, oam_en, oam_we}), 0);
        chk("rstissue_rdata", int'(cpu_rdata), 8'hFF);
        @(posedge clk_4mhz); #1;
        @(negedge clk_4mhz);
        chk("rstnext_ack", int'({cpu_ack, dma_ack}), 0);
        chk("rstnext_en", int'({vram_en, oam_en}), 0);
        chk("rstnext_addr", int'({vram_addr, vram_wdata}), 0);
        @(posedge clk_4mhz); #1;
        rst = 1'b0;
        do_access(1'b0, 1'b1, 16'h8010, 8'h99, 1'b1, 2'd0, 2'd0, 1'b0, lat, ens, rd);
        chk("rstresume_latency", lat, 2);
        chk("rstresume_mem_en", ens, 1);
        ref_vram[16] = 8'h99;
        do_access(1'b0, 1'b0, 16'h8010, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0, lat, ens, rd);
        chk("rstresume_readback", int'(rd), 8'h99);

        // ---------------- randomized vs reference model ----------------
        for (int k = 0; k < 150; k++) begin
            bit isd, w, lcd, dact, blk;
            logic [15:0] a;
            logic [7:0] wd;
            logic [1:0] m, m2;
            int sel;
            isd  = ($urandom_range(0, 2) == 0);
            w    = $urandom_range(0, 1) == 1;
            lcd  = ($urandom_range(0, 3) != 0);
            dact = ($urandom_range(0, 3) == 0);
            m    = 2'($urandom_range(0, 3));
            m2   = 2'($urandom_range(0, 3));
            wd   = 8'($urandom);
            sel  = $urandom_range(0, 3);
            case (sel)
                0: a = 16'h8000 + 16'($urandom_range(0, 15));
                1: a = 16'h9FF0 + 16'($urandom_range(0, 15));
                2: a = 16'hFE00 + 16'($urandom_range(0, 163));
                default: a = 16'($urandom);
            endcase
            blk = blocked_of(isd, a, lcd, m, dact);
            do_access(isd, w, a, wd, lcd, m, m2, dact, lat, ens, rd);
            chk($sformatf("rnd%0d_latency", k), lat, blk ? 1 : 2);
            chk($sformatf("rnd%0d_mem_en", k), ens, blk ? 0 : 1);
            if (blk) chk($sformatf("rnd%0d_rdata", k), int'(rd), 8'hFF);
            else if (!w) chk($sformatf("rnd%0d_rdata", k), int'(rd), int'(ref_read(a)));
            ref_apply(isd, w, a, wd, lcd, m, dact);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/vram_oam_arbiter.md
VRAM_OAM_ARBITER -- requirements
Module: vram_oam_arbiter

Interface
REQ-001 The module SHALL have parameter OPEN_BUS, default 8'hFF, meaning the read data returned for blocked or unmapped accesses.
REQ-002 The module SHALL have port clk_4mhz, input, 1, system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have ports cpu_req / cpu_we / cpu_addr / cpu_wdata, inputs, 1/1/16/8, CPU busmaster request held until acked.
REQ-005 The module SHALL have ports cpu_ack / cpu_rdata, outputs, 1/8, one-cycle completion pulse and read data.
REQ-006 The module SHALL have ports dma_req / dma_we / dma_addr / dma_wdata, inputs, 1/1/16/8, DMA busmaster request held until acked.
REQ-007 The module SHALL have ports dma_ack / dma_rdata, outputs, 1/8, DMA completion pulse and read data.
REQ-008 The module SHALL have inputs dma_active (1, OAM DMA transfer in progress), lcd_on (1, LCDC bit 7) and ppu_mode (2, 0=HBL, 1=VBL, 2=OAM scan, 3=draw).
REQ-009 The module SHALL have VRAM port vram_en / vram_we / vram_addr / vram_wdata as outputs of width 1/1/13/8, and vram_rdata as an input of width 8.
REQ-010 The module SHALL have OAM port oam_en / oam_we / oam_addr / oam_wdata as outputs of width 1/1/8/8, and oam_rdata as an input of width 8; both memories have 1-cycle read latency.

Function
REQ-011 Address decode SHALL be: 8000-9FFF -> VRAM, addr[12:0]; FE00-FE9F -> OAM, addr[7:0]; all other addresses -> unmapped.
REQ-012 The FSM SHALL have states IDLE, ISSUE, WAIT and BLOCKED.
REQ-013 In IDLE, a grant SHALL go to dma_req first, then cpu_req; the winner's address, direction and data are latched.
REQ-014 On a grant, the FSM SHALL go to BLOCKED if the access is unmapped or locked, else to ISSUE.
REQ-015 Lock rules, evaluated only at grant: with lcd_on=1, mode 3 locks VRAM and OAM for the CPU; with lcd_on=1, mode 2 locks OAM for the CPU; while dma_active=1, all CPU accesses are locked.
REQ-016 DMA accesses SHALL never be locked.
REQ-017 ISSUE SHALL assert exactly one memory en for one cycle, with we = latched we, then go to WAIT.
REQ-018 WAIT SHALL pulse the winner's ack, drive its rdata from the addressed memory, then return to IDLE.
REQ-019 BLOCKED SHALL pulse the winner's ack with rdata=OPEN_BUS, perform no memory access, and return to IDLE.
REQ-020 Latency from grant cycle t SHALL be: ack at t+2 for a normal access; ack at t+1 for a blocked or unmapped access.
REQ-021 A locked or unmapped write SHALL be dropped silently but still acked.
REQ-022 When both requesters are pending, DMA SHALL win; the CPU request stays pending and is granted in the next IDLE cycle if DMA has not re-requested.
REQ-023 A ppu_mode change after grant SHALL NOT affect the access in flight.
REQ-024 rdata outputs SHALL hold their last value between acks; ack is high for exactly one cycle per grant.
REQ-025 Throughput SHALL be at most one access per 3 cycles (normal) or per 2 cycles (blocked).

Reset
REQ-026 While rst=1, the FSM SHALL go to IDLE and cpu_ack, dma_ack, vram_en, vram_we, oam_en and oam_we SHALL be 0.
REQ-027 While rst=1, cpu_rdata and dma_rdata SHALL be OPEN_BUS and all address/data outputs SHALL be 0.
REQ-028 Reset asserted mid-access SHALL abort the access without an ack; after rst is released, requests are re-arbitrated from IDLE.

Structure
REQ-029 Package cpu_defs SHALL hold the arbiter state enum, the ppu_mode enum (HBL/VBL/OAM/DRAW) and constants VRAM_BASE=16'h8000, OAM_BASE=16'hFE00 and OAM_END=16'hFE9F.
REQ-030 A sub-module vram_oam_decode SHALL implement combinational address decode plus lock evaluation (region, lock and local address outputs).

Verification
REQ-031 With lcd_on=1 and mode=0, a CPU write of 8000 <- 5A followed by a read of 8000 SHALL give ack at t+2 with rdata=5A.
REQ-032 With lcd_on=1 and mode=3, a CPU read of 8000 SHALL give rdata=FF, ack at t+1 and vram_en never asserted; a CPU write of 9FFF <- 11 SHALL be dropped (a later mode-0 read returns the old value).
REQ-033 With mode=2, a DMA write of FE00 <- 77 SHALL succeed while a CPU read of FE00 in the same mode returns FF; afterwards a mode-0 CPU read of FE00 returns 77.
REQ-034 With cpu_req and dma_req rising in the same cycle, dma_ack SHALL come at t+2 and cpu_ack at t+5; with dma_active=1, a CPU read of 8000 returns FF.
REQ-035 A CPU read of FEA0 SHALL return FF at t+1 with no memory enable asserted; with lcd_on=0 and mode=3, a VRAM access SHALL succeed.
REQ-036 rst asserted in the ISSUE cycle SHALL produce no ack and all outputs at reset values the following cycle; the held request completes normally after rst is released.
